dug_death_sequencer: RTL and testbench
======================================

DUG_DEATH_SEQUENCER -- requirements
Module: dug_death_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FRAMES_PER_STEP, 8, frame ticks per death-animation sprite step
- HOLD_FRAMES, 30, frame ticks of blank hold after the last sprite
- START_LIVES, 3, lives loaded at reset (1..3)

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, system clock
- Reset, in, 1, synchronous, active-high reset
- frame_clk, in, 1, VGA vertical-sync-rate frame clock, sampled in the Clk domain
- endgame_delay, in, 1, one-cycle start strobe from the upstream delay stage
- death_active, out, 1, death sequence in progress
- death_frame, out, 2, dug death sprite index 0..3
- respawn, out, 1, one-cycle pulse: place dug back at spawn
- game_over, out, 1, sticky: no lives left
- lives, out, 2, remaining lives

Function
REQ-003 frame_tick SHALL be frame_clk & ~frame_clk_q, where frame_clk_q is frame_clk registered on Clk; exactly one tick per frame_clk rising edge.
REQ-004 State machine SHALL have states Idle, Anim, Hold, Respawn, Game_Over.
REQ-005 Idle: endgame_delay=1 -> Anim next cycle; step counter := 0; death_frame := 0.
REQ-006 Anim: each frame_tick increments the step counter.
REQ-006a A tick with counter = FRAMES_PER_STEP-1 clears the counter and increments death_frame.
REQ-006b If death_frame = 3 on that tick, the FSM SHALL go to Hold instead, clear the counter, and decrement lives by 1.
REQ-007 Hold: each frame_tick increments the hold counter.
REQ-007a A tick with counter = HOLD_FRAMES-1 SHALL go to Game_Over if lives = 0, else to Respawn.
REQ-008 Respawn: lasts exactly one cycle, then Idle.
REQ-009 Game_Over: terminal until Reset; endgame_delay SHALL be ignored there.
REQ-010 Outputs:
- death_active = 1 in Anim, Hold and Respawn.
- respawn = 1 only in Respawn.
- game_over = 1 only in Game_Over.
- death_frame holds 3 in Hold and returns to 0 in Idle.
REQ-011 endgame_delay asserted in any state other than Idle SHALL be ignored (no restart, no extra life loss).
REQ-012 endgame_delay and frame_tick in the same Idle cycle: enter Anim; that tick SHALL NOT be counted.
REQ-013 lives SHALL decrement only on entry to Hold, never below 0, and never increment except at reset.
REQ-014 Latency: death_active rises on the first Clk edge after endgame_delay is sampled high.
REQ-014a Sequence length: exactly 4*FRAMES_PER_STEP ticks of Anim, then HOLD_FRAMES ticks of Hold.
REQ-015 Counters SHALL be sized for the parameter maxima and SHALL NOT wrap in normal operation.

Reset
REQ-016 On Reset=1 at a Clk edge, the following SHALL take effect the same edge, overriding all other inputs, including mid-Anim and mid-Hold:
- state = Idle
- death_active = 0, death_frame = 0, respawn = 0, game_over = 0
- lives = START_LIVES
- frame_clk_q = 0, both counters = 0

Verification
REQ-017 Single death, defaults: pulse endgame_delay.
- Next cycle death_active = 1, death_frame = 0.
- death_frame = 1 after 8 ticks and 3 after 24 ticks.
- Hold entered at tick 32 with lives = 2.
- After 30 more ticks, respawn = 1 for exactly one cycle, then death_active = 0.
REQ-018 Three deaths, defaults: three complete sequences.
- First two end with a respawn pulse.
- Third ends with game_over = 1, lives = 0 and no respawn pulse.
- A fourth endgame_delay pulse leaves all outputs unchanged.
REQ-019 Ignored strobe: endgame_delay pulsed at tick 10 of Anim -> sequence timing unchanged; lives decrement by only 1.
REQ-020 Reset mid-Hold: Reset after hold tick 15 -> next cycle all outputs at reset values, lives = 3.
REQ-020a After that reset, a new endgame_delay pulse starts a full 32+30 tick sequence.
REQ-021 Simultaneous events: endgame_delay coincident with a frame_tick in Idle -> death_frame first changes 8 further ticks later, not 7.
REQ-022 Held frame_clk: frame_clk held high for 100 Clk cycles during Anim -> the step counter advances by exactly 1.

Source files
------------

// File: rtl/dug_death_sequencer.sv
// Dug death sequencer: plays the four-sprite death animation, holds a blank
// screen, then either respawns dug or latches game over once lives run out.
module dug_death_sequencer #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int HOLD_FRAMES     = 30,
  parameter int START_LIVES     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       endgame_delay,
  output logic       death_active,
  output logic [1:0] death_frame,
  output logic       respawn,
  output logic       game_over,
  output logic [1:0] lives
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [1:0]        LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANIM,
    S_HOLD,
    S_RESPAWN,
    S_GAME_OVER
  } state_t;

  state_t            state_q, state_d;
  logic              frame_clk_q, frame_clk_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        death_frame_q, death_frame_d;
  logic [1:0]        lives_q, lives_d;
  logic              frame_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      frame_clk_q   <= 1'b0;
      step_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      death_frame_q <= 2'd0;
      lives_q       <= LIVES_INIT;
    end else begin
      state_q       <= state_d;
      frame_clk_q   <= frame_clk_d;
      step_cnt_q    <= step_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      death_frame_q <= death_frame_d;
      lives_q       <= lives_d;
    end
  end

  // A tick seen in Idle is deliberately dropped: counting starts in Anim.
  always_comb begin
    frame_tick    = frame_clk & ~frame_clk_q;
    frame_clk_d   = frame_clk;
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    death_frame_d = death_frame_q;
    lives_d       = lives_q;

    case (state_q)
      S_IDLE: begin
        death_frame_d = 2'd0;
        if (endgame_delay) begin
          state_d    = S_ANIM;
          step_cnt_d = '0;
          hold_cnt_d = '0;
        end
      end
      S_ANIM: begin
        if (frame_tick) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (death_frame_q == 2'd3) begin
              state_d    = S_HOLD;
              hold_cnt_d = '0;
              if (lives_q != 2'd0) begin
                lives_d = lives_q - 2'd1;
              end
            end else begin
              death_frame_d = death_frame_q + 2'd1;
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = (lives_q == 2'd0) ? S_GAME_OVER : S_RESPAWN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      S_RESPAWN: begin
        state_d       = S_IDLE;
        death_frame_d = 2'd0;
      end
      S_GAME_OVER: begin
        state_d = S_GAME_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    death_active = (state_q == S_ANIM) || (state_q == S_HOLD) || (state_q == S_RESPAWN);
    respawn      = (state_q == S_RESPAWN);
    game_over    = (state_q == S_GAME_OVER);
    death_frame  = death_frame_q;
    lives        = lives_q;
  end

endmodule

// File: tb/tb_dug_death_sequencer.sv
// Bench for dug_death_sequencer: reset/Idle vector table, hand-written death
// sequences, then random frame clock / strobe traffic against a tick-count model.
module tb_dug_death_sequencer;

  localparam int F = 8;
  localparam int H = 30;
  localparam int L = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       endgame_delay = 1'b0;
  logic       death_active;
  logic [1:0] death_frame;
  logic       respawn;
  logic       game_over;
  logic [1:0] lives;

  int nChecks = 0;
  int nFail = 0;

  dug_death_sequencer #(
    .FRAMES_PER_STEP(F),
    .HOLD_FRAMES(H),
    .START_LIVES(L)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .endgame_delay(endgame_delay),
    .death_active(death_active),
    .death_frame(death_frame),
    .respawn(respawn),
    .game_over(game_over),
    .lives(lives)
  );

  always #5 Clk = ~Clk;

  // Reference model: a sequence is just a count of ticks since its start.
  bit m_prev = 1'b0;
  bit m_in_seq = 1'b0;
  bit m_resp = 1'b0;
  bit m_over = 1'b0;
  int m_ticks = 0;
  int m_lives = L;

  task automatic modelStep(input logic r, input logic f, input logic e);
    bit tick;
    tick   = f && !m_prev;
    m_prev = f;
    if (r) begin
      m_prev = 1'b0; m_in_seq = 1'b0; m_resp = 1'b0; m_over = 1'b0;
      m_ticks = 0; m_lives = L;
    end else if (m_over) begin
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (!m_in_seq) begin
      if (e) begin
        m_in_seq = 1'b1;
        m_ticks  = 0;
      end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == 4 * F && m_lives > 0) m_lives--;
      if (m_ticks == 4 * F + H) begin
        m_in_seq = 1'b0;
        if (m_lives == 0) m_over = 1'b1;
        else m_resp = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] expFrame();
    if (m_over || m_resp) return 8'd3;
    if (m_in_seq) return (m_ticks / F > 3) ? 8'd3 : 8'(m_ticks / F);
    return 8'd0;
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("model death_active", 8'(death_active), 8'(m_in_seq || m_resp));
    checkVal("model death_frame", 8'(death_frame), expFrame());
    checkVal("model respawn", 8'(respawn), 8'(m_resp));
    checkVal("model game_over", 8'(game_over), 8'(m_over));
    checkVal("model lives", 8'(lives), 8'(m_lives));
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic e);
    Reset = r; frame_clk = f; endgame_delay = e;
    @(posedge Clk);
    modelStep(r, f, e);
    #1;
    checkOutput();
  endtask

  // One frame_clk period of four cycles; the tick lands in the first cycle.
  task automatic tickOnce(input logic e);
    applyStimulus(1'b0, 1'b1, e);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       r, f, e;
    logic       act;
    logic [1:0] fr;
    logic       resp, go;
    logic [1:0] lv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{r:1, f:0, e:0, act:0, fr:0, resp:0, go:0, lv:3};
    vecs[1] = '{r:0, f:1, e:0, act:0, fr:0, resp:0, go:0, lv:3};
    vecs[2] = '{r:0, f:0, e:0, act:0, fr:0, resp:0, go:0, lv:3};
    vecs[3] = '{r:0, f:1, e:1, act:1, fr:0, resp:0, go:0, lv:3};
    vecs[4] = '{r:0, f:0, e:1, act:1, fr:0, resp:0, go:0, lv:3};
    vecs[5] = '{r:1, f:1, e:1, act:0, fr:0, resp:0, go:0, lv:3};
    vecs[6] = '{r:0, f:0, e:0, act:0, fr:0, resp:0, go:0, lv:3};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].e);
      checkVal($sformatf("vec%0d active", i), 8'(death_active), 8'(vecs[i].act));
      checkVal($sformatf("vec%0d frame", i), 8'(death_frame), 8'(vecs[i].fr));
      checkVal($sformatf("vec%0d respawn", i), 8'(respawn), 8'(vecs[i].resp));
      checkVal($sformatf("vec%0d game_over", i), 8'(game_over), 8'(vecs[i].go));
      checkVal($sformatf("vec%0d lives", i), 8'(lives), 8'(vecs[i].lv));
    end

    $display("[TB] single death");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkVal("start active", 8'(death_active), 8'd1);
    checkVal("start frame", 8'(death_frame), 8'd0);
    for (int i = 1; i <= 61; i++) begin
      tickOnce(1'b0);
      if (i == 7)  checkVal("tick7 frame", 8'(death_frame), 8'd0);
      if (i == 8)  checkVal("tick8 frame", 8'(death_frame), 8'd1);
      if (i == 24) checkVal("tick24 frame", 8'(death_frame), 8'd3);
      if (i == 31) checkVal("tick31 lives", 8'(lives), 8'd3);
      if (i == 32) checkVal("tick32 lives", 8'(lives), 8'd2);
      if (i == 61) checkVal("tick61 respawn", 8'(respawn), 8'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("death1 respawn", 8'(respawn), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("death1 respawn width", 8'(respawn), 8'd0);
    checkVal("death1 idle active", 8'(death_active), 8'd0);
    checkVal("death1 idle frame", 8'(death_frame), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] second death with ignored strobe");
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 61; i++) tickOnce(i == 10);
    checkVal("death2 no early respawn", 8'(respawn), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("death2 respawn", 8'(respawn), 8'd1);
    checkVal("death2 lives", 8'(lives), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] third death to game over");
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 61; i++) tickOnce(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("death3 game_over", 8'(game_over), 8'd1);
    checkVal("death3 no respawn", 8'(respawn), 8'd0);
    checkVal("death3 lives", 8'(lives), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickOnce(1'b1);
    checkVal("gameover strobe active", 8'(death_active), 8'd0);
    checkVal("gameover strobe sticky", 8'(game_over), 8'd1);
    checkVal("gameover strobe lives", 8'(lives), 8'd0);
    checkVal("gameover strobe frame", 8'(death_frame), 8'd3);

    $display("[TB] reset mid hold");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 32 + 15; i++) tickOnce(1'b0);
    checkVal("midhold active", 8'(death_active), 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkVal("midhold reset active", 8'(death_active), 8'd0);
    checkVal("midhold reset frame", 8'(death_frame), 8'd0);
    checkVal("midhold reset lives", 8'(lives), 8'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 61; i++) tickOnce(1'b0);
    checkVal("post reset still active", 8'(death_active), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("post reset respawn", 8'(respawn), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] simultaneous strobe and tick");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tickOnce(1'b0);
      if (i == 7) checkVal("simul tick7 frame", 8'(death_frame), 8'd0);
      if (i == 8) checkVal("simul tick8 frame", 8'(death_frame), 8'd1);
    end

    $display("[TB] held frame clock");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) tickOnce(1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("held frame", 8'(death_frame), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tickOnce(1'b0);
      if (i == 7) checkVal("held next7 frame", 8'(death_frame), 8'd1);
      if (i == 8) checkVal("held next8 frame", 8'(death_frame), 8'd2);
    end

    $display("[TB] random traffic");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6000; i++) begin
      applyStimulus(1'($urandom_range(0, 999) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
